// File: rtl/muxn_pipe.sv
// Purpose : N-input data selector (clamped binary select) with one registered valid/ready output stage.
// Latency : 1 cycle from accept to y/out_valid when empty; one transfer per cycle when out_ready is held high.
// Backpres: MUXN_PIPE_SKID_EN -> registered in_ready plus skid entry; otherwise in_ready follows out_ready combinationally.
//
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   d [N*WIDTH]         : packed inputs, input k at bits [k*WIDTH +: WIDTH]
//   s [SELW]            : binary select; values >= N clamp to input N-1
//   in_valid / in_ready : producer handshake
//   y [WIDTH]           : selected data, driven from flops only
//   out_valid/out_ready : consumer handshake
//
// Build option: define MUXN_PIPE_SKID_EN for the skid-buffered version.

module muxn_pipe #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SELW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*WIDTH-1:0]   d,
    input  logic [SELW-1:0]      s,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     y,
    output logic                 out_valid,
    input  logic                 out_ready
);

    // One extra bit so N itself is representable when N is a power of two.
    localparam logic [SELW:0]   N_EXT   = (SELW+1)'(N);
    localparam logic [SELW-1:0] SEL_MAX = SELW'(N-1);

    logic [SELW-1:0]  sel;
    logic [WIDTH-1:0] dsel;
    logic [WIDTH-1:0] main_q;
    logic             vld_q;
    logic             accept;
    logic             deliver;

    // Out-of-range select picks the highest input rather than zero or X.
    always_comb begin
        sel  = ({1'b0, s} >= N_EXT) ? SEL_MAX : s;
        dsel = '0;
        for (int k = 0; k < N; k++) begin
            if (sel == SELW'(k)) begin
                dsel = d[k*WIDTH +: WIDTH];
            end
        end
    end

    assign accept    = in_valid && in_ready;
    assign deliver   = vld_q && out_ready;
    assign y         = main_q;
    assign out_valid = vld_q;

`ifdef MUXN_PIPE_SKID_EN

    typedef enum logic [1:0] {
        ST_E = 2'd0,    // empty
        ST_M = 2'd1,    // main register holds the head entry
        ST_F = 2'd2     // main and skid both full
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] skid_q;
    logic             rdy_q;

    assign in_ready = rdy_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_E;
            main_q <= '0;
            skid_q <= '0;
            vld_q  <= 1'b0;
            rdy_q  <= 1'b0;
        end else begin
            // Ready everywhere except F; the F branches below override this.
            rdy_q <= 1'b1;
            case (state)
                ST_E: begin
                    if (accept) begin
                        main_q <= dsel;
                        vld_q  <= 1'b1;
                        state  <= ST_M;
                    end
                end
                ST_M: begin
                    if (accept && deliver) begin
                        main_q <= dsel;
                    end else if (deliver) begin
                        vld_q <= 1'b0;
                        state <= ST_E;
                    end else if (accept) begin
                        // Consumer stalled while in_ready was already promised:
                        // park this beat in the skid register.
                        skid_q <= dsel;
                        rdy_q  <= 1'b0;
                        state  <= ST_F;
                    end
                end
                ST_F: begin
                    if (deliver) begin
                        main_q <= skid_q;
                        state  <= ST_M;
                    end else begin
                        rdy_q <= 1'b0;
                    end
                end
                default: begin
                    vld_q <= 1'b0;
                    state <= ST_E;
                end
            endcase
        end
    end

`else

    // Registered copy of reset keeps in_ready low during and right after reset.
    logic rst_n_q;

    assign in_ready = rst_n_q && (!vld_q || out_ready);

    // vld_q alone encodes the E/M state; F does not exist without the skid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rst_n_q <= 1'b0;
            main_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            rst_n_q <= 1'b1;
            if (accept) begin
                main_q <= dsel;
                vld_q  <= 1'b1;
            end else if (deliver) begin
                vld_q <= 1'b0;
            end
        end
    end

`endif

endmodule

// File: tb/tb_muxn_pipe.sv
// Purpose : exercises muxn_pipe (N=4/WIDTH=32 and N=3/WIDTH=8 instances) with directed vectors.
// Latency : expects y one cycle after accept, one beat per cycle when out_ready is high.
// Backpres: drives out_ready stalls and checks in_ready reaction for the active build.

module tb_muxn_pipe;

    logic         clk = 1'b0;
    logic         rst_n;

    logic [127:0] d;
    logic [1:0]   s;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  y;
    logic         out_valid;
    logic         out_ready;

    logic [23:0]  d2;
    logic [1:0]   s2;
    logic         in_valid2;
    logic         in_ready2;
    logic [7:0]   y2;
    logic         out_valid2;
    logic         out_ready2;

    int           vec = 0;
    int           errs = 0;
    int           dlv_cnt = 0;
    logic [31:0]  exp_q[$];
    logic [7:0]   exp2_q[$];
    logic         stall_hold = 1'b0;
    logic [31:0]  stall_y = '0;

    always #5 clk = ~clk;

    muxn_pipe #(.WIDTH(32), .N(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .d         (d),
        .s         (s),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    muxn_pipe #(.WIDTH(8), .N(3)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .d         (d2),
        .s         (s2),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .y         (y2),
        .out_valid (out_valid2),
        .out_ready (out_ready2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        vec++;
        if (act !== exp_v) begin
            errs++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp_v);
        end
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat, wait (bounded) for acceptance, record the expected output.
    task automatic send_d(input logic [127:0] dv, input logic [1:0] sv, input logic [31:0] ev);
        bit done;
        done     = 1'b0;
        d        = dv;
        s        = sv;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (rst_n && in_ready) begin
                exp_q.push_back(ev);
                done = 1'b1;
            end
            align();
        end
        in_valid = 1'b0;
        chk("send_accepted", {31'b0, done}, 32'd1);
    endtask

    task automatic send(input logic [31:0] v, input logic [1:0] sv);
        logic [127:0] dv;
        dv = {4{~v}};
        dv[int'(sv)*32 +: 32] = v;
        send_d(dv, sv, v);
    endtask

    task automatic send2(input logic [1:0] sv, input logic [7:0] ev);
        bit done;
        done      = 1'b0;
        s2        = sv;
        in_valid2 = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (rst_n && in_ready2) begin
                exp2_q.push_back(ev);
                done = 1'b1;
            end
            align();
        end
        in_valid2 = 1'b0;
        chk("send2_accepted", {31'b0, done}, 32'd1);
    endtask

    // From an empty block: out_valid must first rise at negedge 'lat' and then
    // carry n consecutive values v0, v0+step, ...
    task automatic expect_seq(input string nm, input logic [31:0] v0, input logic [31:0] step,
                              input int n, input int lat);
        for (int i = 1; i < lat; i++) begin
            @(negedge clk);
            chk({nm, "_early_valid"}, {31'b0, out_valid}, 32'd0);
        end
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            chk({nm, "_valid"}, {31'b0, out_valid}, 32'd1);
            chk({nm, "_y"}, y, v0 + i * step);
            if (i < n - 1) @(negedge clk);
        end
    endtask

    // Scoreboard monitor for the main instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            stall_hold = 1'b0;
        end else begin
            if (stall_hold) begin
                chk("stall_valid", {31'b0, out_valid}, 32'd1);
                chk("stall_y", y, stall_y);
            end
            if (out_valid && out_ready) begin
                dlv_cnt++;
                if (exp_q.size() == 0) begin
                    vec++;
                    errs++;
                    $display("FAIL unexpected_out: got y=%h, expected no output", y);
                end else begin
                    chk("scoreboard_y", y, exp_q.pop_front());
                end
            end
            stall_hold = out_valid && !out_ready;
            stall_y    = y;
        end
    end

    // Scoreboard monitor for the N=3 clamp instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp2_q.delete();
        end else if (out_valid2 && out_ready2) begin
            if (exp2_q.size() == 0) begin
                vec++;
                errs++;
                $display("FAIL unexpected_out2: got y2=%h, expected no output", y2);
            end else begin
                chk("scoreboard_y2", {24'b0, y2}, {24'b0, exp2_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, expected finish (%0d vectors)", vec);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rst_n      = 1'b0;
        d          = '0;
        s          = '0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        d2         = {8'h0C, 8'h0B, 8'h0A};
        s2         = '0;
        in_valid2  = 1'b0;
        out_ready2 = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_y", y, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_out_valid2", {31'b0, out_valid2}, 32'd0);
        align();
        rst_n = 1'b1;
        align();
        @(negedge clk);
        chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
        align();

        // Basic select, one beat per cycle, 1-cycle latency
        fork
            begin
                for (int k = 0; k < 4; k++)
                    send_d({32'h4444, 32'h3333, 32'h2222, 32'h1111}, 2'(k), 32'h1111 * (k + 1));
            end
            expect_seq("basic", 32'h1111, 32'h1111, 4, 2);
        join
        @(negedge clk);
        chk("basic_valid_drop", {31'b0, out_valid}, 32'd0);
        align();

        // Clamp on the N=3 instance: s=3 selects input 2
        send2(2'd3, 8'h0C);
        send2(2'd0, 8'h0A);
        send2(2'd1, 8'h0B);
        send2(2'd2, 8'h0C);
        send2(2'd3, 8'h0C);
        repeat (3) align();
        chk("clamp_drained", exp2_q.size(), 32'd0);

        // Simultaneous accept/deliver for 8 cycles
        fork
            begin
                for (int k = 0; k < 8; k++) send(32'h10 + k, 2'(k));
            end
            expect_seq("simul", 32'h10, 32'h1, 8, 2);
        join
        @(negedge clk);
        chk("simul_valid_drop", {31'b0, out_valid}, 32'd0);
        align();

        // Backpressure: 1..6 with out_ready low for 3 cycles mid-stream
        c0 = dlv_cnt;
        fork
            begin
                for (int k = 1; k <= 6; k++) send(k, 2'(k));
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
`ifdef MUXN_PIPE_SKID_EN
                chk("bp_skid_rdy_first", {31'b0, in_ready}, 32'd1);
                @(negedge clk);
                chk("bp_skid_rdy_second", {31'b0, in_ready}, 32'd0);
`else
                chk("bp_stall_valid", {31'b0, out_valid}, 32'd1);
                chk("bp_noskid_rdy", {31'b0, in_ready}, 32'd0);
                @(negedge clk);
`endif
                repeat (2) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        repeat (5) align();
        chk("bp_delivered", dlv_cnt - c0, 32'd6);
        chk("bp_drained", exp_q.size(), 32'd0);

        // Reset with entries held; handshakes on the reset edge are ignored
        out_ready = 1'b0;
        send(32'hA1, 2'd0);
`ifdef MUXN_PIPE_SKID_EN
        send(32'hA2, 2'd1);
`endif
        rst_n     = 1'b0;
        out_ready = 1'b1;
        d         = {4{32'hDEAD}};
        s         = 2'd2;
        in_valid  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_y", y, 32'd0);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd0);
        align();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        align();
        @(negedge clk);
        chk("midrst_release_rdy", {31'b0, in_ready}, 32'd1);
        chk("midrst_release_valid", {31'b0, out_valid}, 32'd0);
        align();
        c0 = dlv_cnt;
        send(32'h55, 2'd1);
        repeat (3) align();
        chk("midrst_fresh_count", dlv_cnt - c0, 32'd1);
        chk("midrst_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
